// File: rtl/pll_mon_pkg.sv
// PLL frequency monitor shared types.
// FSM state encoding used by pll_freq_monitor.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    MEASURE   = 2'd1,
    REPORT    = 2'd2
  } pll_mon_state_t;

endpackage

// File: rtl/pll_freq_monitor_sync_2ff.sv
// Two-flop synchronizer, 1 bit, async active-low reset to 0.
// Ports: clk, rst_n, d (async in), q (synced out).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;
  logic s1_d;
  logic s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pll_freq_monitor.sv
// PLL lock qualifier and gated edge-count frequency monitor on clk.
// In: clk, reset_n, pll_locked, meas_in, enable, clear_fault.
// Out: lock_stable, count_out, count_valid, freq_ok, fault.
module pll_freq_monitor
  import pll_mon_pkg::*;
#(
  parameter int GATE_CYCLES = 4800,
  parameter int EXP_MIN     = 1250,
  parameter int EXP_MAX     = 1300,
  parameter int LOCK_STABLE = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             meas_in,
  input  logic             enable,
  input  logic             clear_fault,
  output logic             lock_stable,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             freq_ok,
  output logic             fault
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int LW = $clog2(LOCK_STABLE + 1);

  logic lock_s;
  logic meas_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  sync_2ff u_meas_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (meas_in),
    .q     (meas_s)
  );

  logic             meas_s3_q, meas_s3_d;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             count_valid_q, count_valid_d;
  logic             freq_ok_q, freq_ok_d;
  logic             fault_q, fault_d;
  pll_mon_state_t   state_q, state_d;

  logic rise;
  logic in_range;
  logic fault_set;
  logic run_ok;

  assign lock_stable = (lock_cnt_q == LW'(LOCK_STABLE));
  assign rise        = meas_s & ~meas_s3_q;
  assign in_range    = (edge_cnt_q >= CNT_W'(EXP_MIN)) &&
                       (edge_cnt_q <= CNT_W'(EXP_MAX));
  assign run_ok      = lock_stable & enable;

  always_comb begin
    meas_s3_d = meas_s;
    lock_cnt_d = '0;
    if (lock_s) begin
      if (lock_cnt_q == LW'(LOCK_STABLE)) lock_cnt_d = lock_cnt_q;
      else                                lock_cnt_d = lock_cnt_q + LW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    gate_cnt_d    = gate_cnt_q;
    edge_cnt_d    = edge_cnt_q;
    count_out_d   = count_out_q;
    count_valid_d = 1'b0;
    freq_ok_d     = freq_ok_q;
    fault_set     = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        if (run_ok) state_d = MEASURE;
      end
      MEASURE: begin
        if (!lock_stable) begin
          // Lock lost mid-window is a fault; enable-drop is not.
          state_d   = WAIT_LOCK;
          freq_ok_d = 1'b0;
          fault_set = 1'b1;
        end else if (!enable) begin
          state_d = WAIT_LOCK;
        end else begin
          gate_cnt_d = gate_cnt_q + GW'(1);
          if (rise && (edge_cnt_q != '1)) edge_cnt_d = edge_cnt_q + CNT_W'(1);
          if (gate_cnt_q == GW'(GATE_CYCLES - 1)) state_d = REPORT;
        end
      end
      REPORT: begin
        // Rises in this cycle are dropped; counters restart clean.
        count_out_d   = edge_cnt_q;
        count_valid_d = 1'b1;
        freq_ok_d     = in_range;
        fault_set     = ~in_range;
        gate_cnt_d    = '0;
        edge_cnt_d    = '0;
        state_d       = run_ok ? MEASURE : WAIT_LOCK;
      end
      default: begin
        state_d    = WAIT_LOCK;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
      end
    endcase
    if (fault_set)        fault_d = 1'b1;
    else if (clear_fault) fault_d = 1'b0;
    else                  fault_d = fault_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meas_s3_q     <= 1'b0;
      lock_cnt_q    <= '0;
      gate_cnt_q    <= '0;
      edge_cnt_q    <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      freq_ok_q     <= 1'b0;
      fault_q       <= 1'b0;
      state_q       <= WAIT_LOCK;
    end else begin
      meas_s3_q     <= meas_s3_d;
      lock_cnt_q    <= lock_cnt_d;
      gate_cnt_q    <= gate_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      freq_ok_q     <= freq_ok_d;
      fault_q       <= fault_d;
      state_q       <= state_d;
    end
  end

  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;
  assign freq_ok     = freq_ok_q;
  assign fault       = fault_q;

endmodule
